// File: rtl/if_prefetch_queue_if.sv
// Fetch-side bundle for if_prefetch_queue: instruction-memory request/response,
// redirect from EXE and the instruction hand-off to ID.
// master: the prefetch queue itself. slave: the surrounding memory/pipeline.
interface if_prefetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers in-order
// responses with their PCs and presents them to ID. A redirect flushes the
// queue and drops every response still in flight.
// Optional feature: define IF_PQ_BYPASS_EN to forward a response straight to ID
// in its arrival cycle when the queue is empty.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  CLK,
    input logic                  Reset,
    if_prefetch_queue_if.master  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [63:0]     mem_q [DEPTH];

    logic        q_empty;
    logic        req_fire;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        bypass;
    logic        enq;
    logic        deq;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
    assign q_empty      = (count_q == '0);

    // Buffered plus in-flight never exceeds DEPTH, so a response always has a slot.
    assign bus.imem_req_valid = Reset && !bus.redirect &&
                                (({1'b0, count_q} + {1'b0, outst_q}) < DepthW);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_drop = bus.imem_rsp_valid && (drop_q != '0);
    assign rsp_keep = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect;

`ifdef IF_PQ_BYPASS_EN
    assign bypass = rsp_keep && q_empty;
`else
    assign bypass = 1'b0;
`endif

    assign bus.id_valid = Reset && !bus.redirect && (!q_empty || bypass);
    assign bus.id_pc    = bypass ? resp_pc_q          : mem_q[rptr_q][63:32];
    assign bus.id_instr = bypass ? bus.imem_rsp_data  : mem_q[rptr_q][31:0];

    assign deq = bus.id_valid && bus.id_ready && !q_empty;
    // A bypassed response consumed by ID this cycle never lands in the queue.
    assign enq = rsp_keep && !(bypass && bus.id_ready);

    // Next-state for PCs, occupancy, in-flight/drop counters and pointers.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        if (bus.redirect) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            count_d    = '0;
            rptr_d     = '0;
            wptr_d     = '0;
            // Everything still in flight after this cycle belongs to the old path.
            outst_d    = outst_q - CntW'(bus.imem_rsp_valid);
            drop_d     = outst_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_keep) resp_pc_d = resp_pc_q + 32'd4;
            if (enq) wptr_d = wptr_q + PtrW'(1);
            if (deq) rptr_d = rptr_q + PtrW'(1);
            count_d = count_q + CntW'(enq) - CntW'(deq);
            outst_d = outst_q + CntW'(req_fire) - CntW'(bus.imem_rsp_valid);
            if (rsp_drop) drop_d = drop_q - CntW'(1);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    // Entry storage {pc, instr}; contents are qualified by count, so no reset.
    always_ff @(posedge CLK) begin
        if (enq) mem_q[wptr_q] <= {resp_pc_q, bus.imem_rsp_data};
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: directed corner sequences, a
// redirect vector table and randomized traffic against a program-order model.
`timescale 1ns/1ps
module tb_if_prefetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_PQ_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif

    logic CLK   = 1'b0;
    logic Reset = 1'b0;

    if_prefetch_queue_if bus ();

    if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } mem_req_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
        logic [31:0] exp_pc2;
    } redir_vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;

    // stimulus controls
    bit          c_redirect = 0;
    logic [31:0] c_redirect_pc = '0;
    bit          c_id_ready = 1;
    bit          c_req_ready = 1;
    bit          c_rand = 0;
    int unsigned c_lat_min = 1;
    int unsigned c_lat_max = 1;

    // memory model and program-order reference
    mem_req_t    pend[$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_id;
    int          occ;
    bit          prev_hold;
    logic [31:0] prev_pc, prev_instr;

    // per-cycle observations
    bit          o_req_valid, o_req_fire, o_id_valid, o_id_fire, o_rsp, o_rsp_stale;
    logic [31:0] o_req_addr, o_id_pc;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock cycle: drive at posedge+1, sample/model at posedge+2.
    task automatic step();
        mem_req_t    m;
        bit          red;
        int unsigned lat;
        red = c_redirect;
        bus.redirect_pc = c_redirect_pc;
        if (c_rand && $urandom_range(0, 24) == 0) begin
            red = 1'b1;
            bus.redirect_pc = $urandom();
        end
        bus.redirect       = red;
        bus.id_ready       = c_rand ? ($urandom_range(0, 3) != 0) : c_id_ready;
        bus.imem_req_ready = c_rand ? ($urandom_range(0, 3) != 0) : c_req_ready;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom();
        o_rsp = 0;
        o_rsp_stale = 0;
        if (Reset && pend.size() != 0 && pend[0].due <= cyc) begin
            m = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
            o_rsp = 1;
            o_rsp_stale = m.stale;
        end
        #1;
        o_req_valid = bus.imem_req_valid;
        o_req_addr  = bus.imem_req_addr;
        o_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
        o_id_valid  = bus.id_valid;
        o_id_fire   = bus.id_valid && bus.id_ready;
        o_id_pc     = bus.id_pc;
        if (!Reset) begin
            check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
            pend.delete();
            exp_fetch = RESET_PC;
            exp_id = RESET_PC;
            occ = 0;
            prev_hold = 0;
        end else if (red) begin
            check("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
            check("redir_id_valid", {31'd0, bus.id_valid}, 32'd0);
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_fetch = {bus.redirect_pc[31:2], 2'b00};
            exp_id = exp_fetch;
            occ = 0;
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("head_hold_valid", {31'd0, bus.id_valid}, 32'd1);
                check("head_hold_pc", bus.id_pc, prev_pc);
                check("head_hold_instr", bus.id_instr, prev_instr);
            end
            if (o_rsp && !o_rsp_stale) occ++;
            if (o_id_fire) begin
                check("id_pc", bus.id_pc, exp_id);
                check("id_instr", bus.id_instr, mem_word(exp_id));
                exp_id += 32'd4;
                occ--;
            end
            if (o_req_fire) begin
                check("req_addr", bus.imem_req_addr, exp_fetch);
                exp_fetch += 32'd4;
                lat = $urandom_range(c_lat_min, c_lat_max);
                pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat, stale: 1'b0});
            end
            check("inflight_bound", {31'd0, (occ + int'(pend.size())) <= int'(DEPTH)}, 32'd1);
            prev_hold  = bus.id_valid && !bus.id_ready;
            prev_pc    = bus.id_pc;
            prev_instr = bus.id_instr;
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (3) step();
        Reset = 1'b1;
    endtask

    task automatic wait_id(input string name, output logic [31:0] pc);
        pc = 'x;
        for (int k = 0; k < 60; k++) begin
            step();
            if (o_id_fire) begin
                pc = o_id_pc;
                return;
            end
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        redir_vec_t  vecs[5];
        logic [31:0] pc;
        int          fires, stale_cnt, k;
        bit          seen;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vecs[2] = '{32'h0000_1FFE, 32'h0000_1FFC, 32'h0000_1FFC, 32'h0000_2000, 32'h0000_2004};
        vecs[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        vecs[4] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        @(posedge CLK);
        #1;

        // Reset release: first request goes to RESET_PC, then 0,4,8,... delivered.
        do_reset();
        step();
        check("first_req_valid", {31'd0, o_req_valid}, 32'd1);
        check("first_req_addr", o_req_addr, RESET_PC);
        for (int i = 0; i < 6; i++) begin
            wait_id("stream", pc);
            check("stream_pc", pc, RESET_PC + 32'(4 * i));
        end

        // ID stalled: queue fills to DEPTH, no requests, head held, nothing lost.
        do_reset();
        c_id_ready = 0;
        repeat (10) step();
        check("stall_req_valid", {31'd0, o_req_valid}, 32'd0);
        check("stall_id_valid", {31'd0, o_id_valid}, 32'd1);
        check("stall_head_pc", o_id_pc, RESET_PC);
        check("stall_entries", 32'(occ), 32'(DEPTH));
        check("stall_outstanding", 32'(pend.size()), 32'd0);
        c_id_ready = 1;
        for (int i = 0; i < 6; i++) begin
            wait_id("release", pc);
            check("release_pc", pc, RESET_PC + 32'(4 * i));
        end

        // Three in flight, redirect to 0x100: three stale responses dropped.
        do_reset();
        c_lat_min = 8;
        c_lat_max = 8;
        fires = 0;
        k = 0;
        while (fires < 3 && k < 10) begin
            step();
            if (o_req_fire) fires++;
            k++;
        end
        c_req_ready = 0;
        check("three_outstanding", 32'(pend.size()), 32'd3);
        c_lat_min = 1;
        c_lat_max = 1;
        c_req_ready = 1;
        c_redirect = 1;
        c_redirect_pc = 32'h0000_0100;
        step();
        c_redirect = 0;
        stale_cnt = 0;
        seen = 0;
        pc = 'x;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (o_rsp_stale) stale_cnt++;
            if (o_id_fire) begin
                seen = 1;
                pc = o_id_pc;
            end
        end
        check("drop3_first_pc", pc, 32'h0000_0100);
        check("drop3_stale_before", 32'(stale_cnt), 32'd3);
        wait_id("drop3_second", pc);
        check("drop3_second_pc", pc, 32'h0000_0104);

        // Redirect in the same cycle as a response and id_ready.
        repeat (6) step();
        c_redirect = 1;
        c_redirect_pc = 32'h0000_0300;
        step();
        c_redirect = 0;
        check("redir_rsp_present", {31'd0, o_rsp}, 32'd1);
        check("redir_no_dequeue", {31'd0, o_id_fire}, 32'd0);
        wait_id("redir_rsp_first", pc);
        check("redir_rsp_first_pc", pc, 32'h0000_0300);
        wait_id("redir_rsp_second", pc);
        check("redir_rsp_second_pc", pc, 32'h0000_0304);

        // Redirect vector table: alignment and address wrap.
        foreach (vecs[i]) begin
            repeat (3) step();
            c_redirect = 1;
            c_redirect_pc = vecs[i].target;
            step();
            c_redirect = 0;
            step();
            check("vec_req_valid", {31'd0, o_req_valid}, 32'd1);
            check("vec_req_addr", o_req_addr, vecs[i].exp_addr);
            wait_id("vec_pc0", pc);
            check("vec_pc0", pc, vecs[i].exp_pc0);
            wait_id("vec_pc1", pc);
            check("vec_pc1", pc, vecs[i].exp_pc1);
            wait_id("vec_pc2", pc);
            check("vec_pc2", pc, vecs[i].exp_pc2);
        end

        // Response-to-ID latency from an empty queue with nothing in flight.
        c_req_ready = 0;
        repeat (10) step();
        c_req_ready = 1;
        c_redirect = 1;
        c_redirect_pc = 32'h0000_0400;
        step();
        c_redirect = 0;
        step();
        check("post_redir_req_valid", {31'd0, o_req_valid}, 32'd1);
        check("post_redir_req_addr", o_req_addr, 32'h0000_0400);
        step();
        check("rsp_cycle_id_valid", {31'd0, o_id_valid}, BYP);
        step();
        check("rsp_next_id_valid", {31'd0, o_id_valid}, 32'd1);

        // Randomized traffic with random redirects and one mid-run reset.
        c_rand = 1;
        c_lat_min = 1;
        c_lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            Reset = !(i >= 1500 && i < 1503);
            step();
        end
        Reset = 1'b1;

        // Traffic still flows once everything is ready again.
        c_rand = 0;
        c_id_ready = 1;
        c_req_ready = 1;
        fires = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (o_id_fire) fires++;
        end
        check("liveness", {31'd0, fires >= 10}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries and maximum in-flight fetches (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: instruction memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid, input, 1 bit: instruction word returned (in order, no backpressure).
REQ-009 SHALL have port imem_rsp_data, input, 32 bits: returned instruction.
REQ-010 SHALL have port redirect, input, 1 bit: branch/jump taken from EXE; flush.
REQ-011 SHALL have port redirect_pc, input, 32 bits: new fetch target.
REQ-012 SHALL have port id_valid, output, 1 bit: instruction available to ID.
REQ-013 SHALL have port id_ready, input, 1 bit: ID accepts (low during load-use bubble).
REQ-014 SHALL have port id_pc, output, 32 bits: PC of presented instruction.
REQ-015 SHALL have port id_instr, output, 32 bits: presented instruction.

Function
REQ-016 SHALL accept a request when imem_req_valid && imem_req_ready, then fetch_pc += 4 (mod 2^32) and outstanding += 1.
REQ-017 SHALL drive imem_req_valid = !redirect && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
REQ-018 SHALL hold count + outstanding <= DEPTH at all times, so a response never meets a full queue.
REQ-019 SHALL, on each imem_rsp_valid with drop_cnt > 0, discard the response and decrement drop_cnt and outstanding.
REQ-020 SHALL, on each imem_rsp_valid with drop_cnt == 0, enqueue {resp_pc, imem_rsp_data}, then resp_pc += 4 and outstanding -= 1.
REQ-021 SHALL drive id_valid = (count != 0) && !redirect; id_pc and id_instr are the head entry.
REQ-022 SHALL dequeue the head when id_valid && id_ready, and SHALL hold the head stable while id_ready is low.
REQ-023 SHALL support enqueue and dequeue in the same cycle with count unchanged.
REQ-024 SHALL, on redirect (priority over all else): empty the queue; set fetch_pc = resp_pc = redirect_pc; set drop_cnt = outstanding - imem_rsp_valid and outstanding likewise; discard any same-cycle response; issue no request that cycle.
REQ-025 SHALL issue the first request to redirect_pc in the cycle after redirect.
REQ-026 SHALL ignore the low 2 bits of redirect_pc (forced to 00).
REQ-027 SHALL use circular read/write pointers, log2(DEPTH) bits each, that wrap; full/empty are derived from count.

Reset
REQ-028 SHALL, while Reset is low, set fetch_pc = resp_pc = RESET_PC, count = outstanding = drop_cnt = 0 and pointers = 0, and force imem_req_valid = 0 and id_valid = 0.
REQ-029 SHALL, on asserting Reset mid-operation, abandon in-flight requests; instruction memory is reset together with this block.
REQ-030 SHALL issue the first request to RESET_PC in the first cycle after Reset deasserts.

Configuration
REQ-031 SHALL, with IF_PQ_BYPASS_EN defined, forward a kept response directly to id_valid/id_pc/id_instr in the same cycle when the queue is empty; if id_ready is also high, the entry is not enqueued.
REQ-032 SHALL, without IF_PQ_BYPASS_EN, always enqueue responses, giving a minimum 1-cycle response-to-id_valid latency.

Verification
REQ-033 SHALL be verified with: reset release, imem_req_ready=1, 1-cycle memory latency, id_ready=1 -> addresses 0,4,8,... issued; id_pc sequence 0,4,8 with matching instr.
REQ-034 SHALL be verified with: id_ready=0 for 10 cycles -> exactly 4 entries plus 0 outstanding; imem_req_valid low; head pc 0 held stable; no loss after release.
REQ-035 SHALL be verified with: 3 requests outstanding, redirect to 0x100 -> next 3 responses dropped; next id_pc=0x100, then 0x104.
REQ-036 SHALL be verified with: redirect coinciding with imem_rsp_valid and id_ready -> that response discarded, nothing dequeued, drop_cnt = outstanding-1.
REQ-037 SHALL be verified with: fetch_pc=0xFFFF_FFFC -> next address 0x0000_0000 (wrap); redirect_pc=0x103 -> fetch at 0x100.
REQ-038 SHALL be verified with: IF_PQ_BYPASS_EN defined, empty queue, response arrives -> id_valid in the same cycle; undefined -> one cycle later.
